// File: rtl/i2c_oled_sequencer_if.sv
// Byte stream between the OLED sequencer (master modport) and the I2C byte master (slave modport).
// Handshake: a byte moves on a cycle with m_valid && m_ready; once m_valid is high every m_* field
// holds until that cycle, and m_valid only falls without a transfer on reset or after m_nack.
interface i2c_oled_sequencer_if;
  logic       m_valid;
  logic       m_ready;
  logic       m_first;
  logic       m_last;
  logic [6:0] m_slave_addr;
  logic       m_rw;
  logic [7:0] m_control;
  logic [7:0] m_data;
  logic       m_nack;

  modport master (
    output m_valid, m_first, m_last, m_slave_addr, m_rw, m_control, m_data,
    input  m_ready, m_nack
  );

  modport slave (
    input  m_valid, m_first, m_last, m_slave_addr, m_rw, m_control, m_data,
    output m_ready, m_nack
  );
endinterface

// File: rtl/i2c_oled_sequencer.sv
// SSD1306-class OLED sequencer: power-up delay, init command table, then full-frame pushes
// (address window + GDDRAM data) on request, with request queuing and sticky NACK error.
module i2c_oled_sequencer #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h3C,
  parameter int         CMD_COUNT      = 25,
  parameter int         COLS           = 128,
  parameter int         PAGES          = 8,
  parameter int         STARTUP_CYCLES = 2700000,
  parameter int         CMD_AW         = (CMD_COUNT > 1) ? $clog2(CMD_COUNT) : 1,
  parameter int         FB_AW          = (COLS * PAGES > 1) ? $clog2(COLS * PAGES) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              fb_refresh,
  output logic [CMD_AW-1:0] cmd_addr,
  input  logic [7:0]        cmd_data,
  output logic [FB_AW-1:0]  fb_addr,
  input  logic [7:0]        fb_data,
  i2c_oled_sequencer_if.master m,
  output logic              init_done,
  output logic              busy,
  output logic              frame_done,
  output logic              error,
  output logic [2:0]        dbg_state_o
);

  localparam int FB_BYTES = COLS * PAGES;
  localparam int CNT_W    = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CMD_AW-1:0] CMD_LAST  = CMD_AW'(CMD_COUNT - 1);
  localparam logic [CMD_AW-1:0] CMD_ONE   = CMD_AW'(1);
  localparam logic [FB_AW-1:0]  FB_LAST   = FB_AW'(FB_BYTES - 1);
  localparam logic [FB_AW-1:0]  FB_ONE    = FB_AW'(1);
  localparam logic [2:0]        WIN_LAST  = 3'd5;
  localparam logic [2:0]        WIN_ONE   = 3'd1;
  localparam logic [7:0]        COL_END   = 8'(COLS - 1);
  localparam logic [7:0]        PAGE_END  = 8'(PAGES - 1);
  localparam logic [7:0]        CTRL_CMD  = 8'h00;
  localparam logic [7:0]        CTRL_DATA = 8'h40;

  typedef enum logic [2:0] {
    S_WAIT,
    S_INIT_FETCH,
    S_INIT_SEND,
    S_READY,
    S_WIN_SEND,
    S_FB_FETCH,
    S_FB_SEND,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CMD_AW-1:0] cidx_q, cidx_d;
  logic [FB_AW-1:0]  fidx_q, fidx_d;
  logic [2:0]        widx_q, widx_d;
  logic              m_valid_q, m_valid_d;
  logic              m_first_q, m_first_d;
  logic              m_last_q, m_last_d;
  logic [7:0]        m_control_q, m_control_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              init_done_q, init_done_d;
  logic              frame_done_q, frame_done_d;
  logic              error_q, error_d;
  logic              pending_q, pending_d;

  logic accept;
  logic in_xfer;

  // Column range 0..COLS-1 (0x21) then page range 0..PAGES-1 (0x22).
  function automatic logic [7:0] win_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    win_byte = 8'h21;
      3'd1:    win_byte = 8'h00;
      3'd2:    win_byte = COL_END;
      3'd3:    win_byte = 8'h22;
      3'd4:    win_byte = 8'h00;
      default: win_byte = PAGE_END;
    endcase
  endfunction

  assign accept  = m_valid_q && m.m_ready;
  assign in_xfer = (state_q == S_INIT_FETCH) || (state_q == S_INIT_SEND) ||
                   (state_q == S_WIN_SEND)   || (state_q == S_FB_FETCH)  ||
                   (state_q == S_FB_SEND);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      cidx_q       <= '0;
      fidx_q       <= '0;
      widx_q       <= '0;
      m_valid_q    <= 1'b0;
      m_first_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_control_q  <= '0;
      m_data_q     <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cidx_q       <= cidx_d;
      fidx_q       <= fidx_d;
      widx_q       <= widx_d;
      m_valid_q    <= m_valid_d;
      m_first_q    <= m_first_d;
      m_last_q     <= m_last_d;
      m_control_q  <= m_control_d;
      m_data_q     <= m_data_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cidx_d       = cidx_q;
    fidx_d       = fidx_q;
    widx_d       = widx_q;
    m_valid_d    = m_valid_q;
    m_first_d    = m_first_q;
    m_last_d     = m_last_q;
    m_control_d  = m_control_q;
    m_data_d     = m_data_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    error_d      = error_q;
    pending_d    = pending_q;

    // Requests arriving while busy collapse into a single queued frame.
    if (fb_refresh && ((state_q == S_WAIT) || in_xfer)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_WAIT: begin
        if (start || (cnt_q == CNT_LAST)) begin
          cnt_d   = '0;
          cidx_d  = '0;
          state_d = S_INIT_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_INIT_FETCH: begin
        m_valid_d   = 1'b1;
        m_control_d = CTRL_CMD;
        m_data_d    = cmd_data;
        m_first_d   = (cidx_q == '0);
        m_last_d    = (cidx_q == CMD_LAST);
        state_d     = S_INIT_SEND;
      end
      S_INIT_SEND: begin
        if (accept) begin
          m_valid_d = 1'b0;
          m_first_d = 1'b0;
          m_last_d  = 1'b0;
          if (cidx_q == CMD_LAST) begin
            cidx_d      = '0;
            init_done_d = 1'b1;
            state_d     = S_READY;
          end else begin
            cidx_d  = cidx_q + CMD_ONE;
            state_d = S_INIT_FETCH;
          end
        end
      end
      S_READY: begin
        if (start) begin
          cidx_d      = '0;
          init_done_d = 1'b0;
          state_d     = S_INIT_FETCH;
        end else if (fb_refresh || pending_q) begin
          pending_d   = 1'b0;
          widx_d      = '0;
          m_valid_d   = 1'b1;
          m_first_d   = 1'b1;
          m_last_d    = 1'b0;
          m_control_d = CTRL_CMD;
          m_data_d    = win_byte(3'd0);
          state_d     = S_WIN_SEND;
        end
      end
      S_WIN_SEND: begin
        // Valid drops for one cycle between window bytes to keep the 2-cycle byte pacing.
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = win_byte(widx_q);
          m_first_d = (widx_q == '0);
          m_last_d  = (widx_q == WIN_LAST);
        end else if (m.m_ready) begin
          m_valid_d = 1'b0;
          m_first_d = 1'b0;
          m_last_d  = 1'b0;
          if (widx_q == WIN_LAST) begin
            widx_d  = '0;
            fidx_d  = '0;
            state_d = S_FB_FETCH;
          end else begin
            widx_d = widx_q + WIN_ONE;
          end
        end
      end
      S_FB_FETCH: begin
        m_valid_d   = 1'b1;
        m_control_d = CTRL_DATA;
        m_data_d    = fb_data;
        m_first_d   = (fidx_q == '0);
        m_last_d    = (fidx_q == FB_LAST);
        state_d     = S_FB_SEND;
      end
      S_FB_SEND: begin
        if (accept) begin
          m_valid_d = 1'b0;
          m_first_d = 1'b0;
          m_last_d  = 1'b0;
          if (fidx_q == FB_LAST) begin
            fidx_d       = '0;
            frame_done_d = 1'b1;
            state_d      = S_READY;
          end else begin
            fidx_d  = fidx_q + FB_ONE;
            state_d = S_FB_FETCH;
          end
        end
      end
      S_ERROR: begin
        if (start) begin
          error_d     = 1'b0;
          cidx_d      = '0;
          init_done_d = 1'b0;
          state_d     = S_INIT_FETCH;
        end
      end
      default: state_d = S_WAIT;
    endcase

    // A NACK aborts whatever transaction is in flight and drops any queued frame.
    if (m.m_nack && in_xfer) begin
      m_valid_d = 1'b0;
      m_first_d = 1'b0;
      m_last_d  = 1'b0;
      error_d   = 1'b1;
      pending_d = 1'b0;
      cidx_d    = '0;
      fidx_d    = '0;
      widx_d    = '0;
      state_d   = S_ERROR;
    end
  end

  assign cmd_addr       = cidx_q;
  assign fb_addr        = fidx_q;
  assign m.m_valid      = m_valid_q;
  assign m.m_first      = m_first_q;
  assign m.m_last       = m_last_q;
  assign m.m_control    = m_control_q;
  assign m.m_data       = m_data_q;
  assign m.m_slave_addr = SLAVE_ADDR;
  assign m.m_rw         = 1'b0;
  assign init_done      = init_done_q;
  assign frame_done     = frame_done_q;
  assign error          = error_q;
  assign busy           = (state_q != S_READY) && (state_q != S_ERROR);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_i2c_oled_sequencer.sv
// Self-checking bench for i2c_oled_sequencer: byte-stream reference queue, per-cycle compare
// process, and directed plus randomized scenarios (backpressure, queued requests, NACK, reset).
module tb_i2c_oled_sequencer;
  localparam int         CMD_COUNT = 3;
  localparam int         COLS      = 4;
  localparam int         PAGES     = 2;
  localparam int         STARTUP   = 10;
  localparam int         FBN       = COLS * PAGES;
  localparam logic [6:0] ADDR      = 7'h3C;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       fb_refresh = 1'b0;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [2:0] fb_addr;
  logic [7:0] fb_data;
  logic       init_done, busy, frame_done, error;
  logic [2:0] dbg_state;
  logic [7:0] cmd_tab [4];
  logic [7:0] fb_mem  [FBN];

  logic rnd_ready = 1'b0;
  logic ready_force = 1'b1;
  logic ready_rnd = 1'b1;
  logic nack = 1'b0;

  i2c_oled_sequencer_if bus();
  assign bus.m_ready = rnd_ready ? ready_rnd : ready_force;
  assign bus.m_nack  = nack;
  assign cmd_data    = cmd_tab[cmd_addr];
  assign fb_data     = fb_mem[fb_addr];

  i2c_oled_sequencer #(
    .SLAVE_ADDR(ADDR), .CMD_COUNT(CMD_COUNT), .COLS(COLS), .PAGES(PAGES),
    .STARTUP_CYCLES(STARTUP)
  ) dut (
    .CLK(clk), .RST(rst), .start(start), .fb_refresh(fb_refresh),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .fb_addr(fb_addr), .fb_data(fb_data),
    .m(bus), .init_done(init_done), .busy(busy), .frame_done(frame_done),
    .error(error), .dbg_state_o(dbg_state)
  );

  always @(posedge clk) begin
    #1;
    ready_rnd = ($urandom_range(0, 3) != 0);
  end

  // scoreboard: {first, last, control, data} of every byte the master must accept, in order
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;
  int frames_seen = 0;
  int exp_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic f, input logic l, input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back({f, l, c, d});
  endtask

  task automatic push_init();
    for (int i = 0; i < CMD_COUNT; i++) push(i == 0, i == CMD_COUNT - 1, 8'h00, cmd_tab[i]);
  endtask

  task automatic push_frame();
    logic [7:0] win [6];
    win[0] = 8'h21; win[1] = 8'h00; win[2] = 8'(COLS - 1);
    win[3] = 8'h22; win[4] = 8'h00; win[5] = 8'(PAGES - 1);
    for (int i = 0; i < 6; i++) push(i == 0, i == 5, 8'h00, win[i]);
    for (int i = 0; i < FBN; i++) push(i == 0, i == FBN - 1, 8'h40, fb_mem[i]);
    exp_frames++;
  endtask

  task automatic pulse_refresh();
    fb_refresh = 1'b1;
    tick();
    fb_refresh = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk({name, " idle within budget"}, n < budget, 1'b1);
    repeat (6) tick();
  endtask

  // Wait until a data byte is on offer; want < 0 accepts any framebuffer address.
  task automatic wait_data(input string name, input int want, input int budget);
    int n = 0;
    while (!(bus.m_valid && bus.m_control == 8'h40 && (want < 0 || int'(fb_addr) == want))
           && n < budget) begin
      tick();
      n++;
    end
    chk({name, " data phase reached"}, n < budget, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " m_valid"}, bus.m_valid, 1'b0);
    chk({tag, " m_first"}, bus.m_first, 1'b0);
    chk({tag, " m_last"}, bus.m_last, 1'b0);
    chk({tag, " m_data"}, bus.m_data, 8'h00);
    chk({tag, " m_control"}, bus.m_control, 8'h00);
    chk({tag, " cmd_addr"}, cmd_addr, 2'd0);
    chk({tag, " fb_addr"}, fb_addr, 3'd0);
    chk({tag, " init_done"}, init_done, 1'b0);
    chk({tag, " busy"}, busy, 1'b1);
    chk({tag, " frame_done"}, frame_done, 1'b0);
    chk({tag, " error"}, error, 1'b0);
  endtask

  // Releases reset with m_ready high and pins the startup latency and init completion cycle.
  task automatic run_init_timing(input string tag);
    int first_v = 0;
    int done_c = 0;
    push_init();
    rst = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (bus.m_valid && first_v == 0) first_v = cyc;
      if (init_done) begin
        done_c = cyc;
        break;
      end
    end
    chk({tag, " first m_valid cycle"}, first_v, 11);
    chk({tag, " init_done cycle"}, done_c, 16);
  endtask

  // compare process: every cycle out of reset
  logic        prev_hold = 1'b0;
  logic        prev_nack = 1'b0;
  logic        fd_due = 1'b0;
  logic [17:0] held = '0;

  always @(negedge clk) begin
    logic [17:0] cur;
    logic [17:0] e;
    cur = {bus.m_first, bus.m_last, bus.m_control, bus.m_data};
    if (rst) begin
      prev_hold = 1'b0;
      prev_nack = 1'b0;
      fd_due    = 1'b0;
    end else begin
      chk("m_slave_addr", bus.m_slave_addr, ADDR);
      chk("m_rw", bus.m_rw, 1'b0);
      chk("cmd_addr in range", cmd_addr < CMD_COUNT, 1'b1);
      if (prev_hold && !prev_nack) begin
        chk("held m_valid", bus.m_valid, 1'b1);
        chk("held fields", cur, held);
      end
      chk("frame_done", frame_done, fd_due);
      if (frame_done) frames_seen++;
      fd_due = 1'b0;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected byte: got %0h, none required at %0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          chk("accepted byte", cur, e);
          if (e[16] && e[15:8] == 8'h40) fd_due = 1'b1;
        end
      end
      prev_hold = bus.m_valid && !bus.m_ready;
      held      = cur;
      prev_nack = bus.m_nack;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] hold_d;
    logic       found;
    logic       saw_v;
    cmd_tab[0] = 8'hAE; cmd_tab[1] = 8'hA8; cmd_tab[2] = 8'hAF; cmd_tab[3] = 8'hEE;
    for (int i = 0; i < FBN; i++) fb_mem[i] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    run_init_timing("power-up");

    // first frame with fb_data = address; literal window bytes for COLS=4, PAGES=2
    push(1, 0, 8'h00, 8'h21); push(0, 0, 8'h00, 8'h00); push(0, 0, 8'h00, 8'h03);
    push(0, 0, 8'h00, 8'h22); push(0, 0, 8'h00, 8'h00); push(0, 1, 8'h00, 8'h01);
    for (int i = 0; i < FBN; i++) push(i == 0, i == FBN - 1, 8'h40, 8'(i));
    exp_frames++;
    pulse_refresh();
    wait_idle("frame1", 200);
    chk("frames after first refresh", frames_seen, 1);
    chk("fb_addr back to 0", fb_addr, 3'd0);

    // 5-cycle backpressure in the middle of a frame
    for (int i = 0; i < FBN; i++) fb_mem[i] = 8'($urandom);
    push_frame();
    pulse_refresh();
    wait_data("stall", 3, 200);
    ready_force = 1'b0;
    hold_d = bus.m_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stalled m_data", bus.m_data, hold_d);
      chk("stalled m_valid", bus.m_valid, 1'b1);
    end
    ready_force = 1'b1;
    wait_idle("stall frame", 200);
    chk("frames after stall", frames_seen, exp_frames);

    // start beats fb_refresh in READY; three requests during init collapse to one frame
    push_init();
    start = 1'b1;
    fb_refresh = 1'b1;
    tick();
    start = 1'b0;
    fb_refresh = 1'b0;
    chk("init_done cleared by start", init_done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      fb_refresh = 1'b1;
      tick();
      fb_refresh = 1'b0;
      tick();
    end
    push_frame();
    wait_data("queued frame", -1, 200);
    push_frame();
    fb_refresh = 1'b1;
    start = 1'b1;
    tick();
    fb_refresh = 1'b0;
    start = 1'b0;
    wait_idle("queued frames", 400);
    chk("frames after queued requests", frames_seen, exp_frames);
    chk("init_done after rerun", init_done, 1'b1);

    // NACK on window byte 3 (0x22)
    push(1, 0, 8'h00, 8'h21); push(0, 0, 8'h00, 8'h00); push(0, 0, 8'h00, 8'(COLS - 1));
    pulse_refresh();
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (bus.m_valid && bus.m_control == 8'h00 && bus.m_data == 8'h22) begin
        ready_force = 1'b0;
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("window byte 3 offered", found, 1'b1);
    nack = 1'b1;
    tick();
    nack = 1'b0;
    chk("nack m_valid", bus.m_valid, 1'b0);
    chk("nack error", error, 1'b1);
    chk("nack busy", busy, 1'b0);
    ready_force = 1'b1;
    pulse_refresh();
    saw_v = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      saw_v = saw_v | bus.m_valid;
    end
    chk("refresh ignored in error", saw_v, 1'b0);
    chk("error sticky", error, 1'b1);
    push_init();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start clears error", error, 1'b0);
    tick();
    chk("init restarts without delay", bus.m_valid, 1'b1);
    wait_idle("re-init", 100);
    chk("init_done after recovery", init_done, 1'b1);
    chk("no frame queued across nack", frames_seen, exp_frames);

    // randomized frames with random backpressure and random extra requests
    rnd_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < FBN; i++) fb_mem[i] = 8'($urandom);
      push_frame();
      pulse_refresh();
      if ($urandom_range(0, 1) == 1) begin
        wait_data("random extra", -1, 300);
        push_frame();
        for (int k = 0, kn = $urandom_range(1, 3); k < kn; k++) begin
          pulse_refresh();
          if ($urandom_range(0, 1) == 1) tick();
        end
      end
      wait_idle("random frame", 2000);
    end
    rnd_ready = 1'b0;
    chk("frames after random phase", frames_seen, exp_frames);

    // reset in the middle of a frame, then the whole sequence again
    push_frame();
    exp_frames--;
    pulse_refresh();
    wait_data("reset point", 4, 200);
    ready_force = 1'b0;
    rst = 1'b1;
    tick();
    check_reset("mid-frame reset");
    exp_q.delete();
    ready_force = 1'b1;
    tick();
    run_init_timing("after reset");
    for (int i = 0; i < FBN; i++) fb_mem[i] = 8'($urandom);
    push_frame();
    pulse_refresh();
    wait_idle("frame after reset", 300);
    chk("frames at end", frames_seen, exp_frames);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
